dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 13 +
 rtl/dmem_responder.sv | 73 +++++++
 tb/tb_dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between a requester (master) and dmem_responder (slave)
interface dmem_responder_if;
  logic req;
  logic we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic busy;
  logic ack;
  logic [15:0] rdata;
  logic err;
  modport master (output req, we, addr, wdata, input busy, ack, rdata, err);
  modport slave (input req, we, addr, wdata, output busy, ack, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency 16-bit word memory, one access in flight, optional range check via DMEM_RANGE_CHK_EN
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of dmem_responder_if (req/we/addr/wdata in, busy/ack/rdata/err out)
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, busy_q, ack_q, err_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic [15:0] mem [DEPTH];
  logic accept, go_resp, a_we, oob;
  logic [15:0] a_addr, a_wdata;
  // With LATENCY = 1 the RESP-entry edge is the acceptance edge, so the access
  // fields come straight from the bus in IDLE and from the latches otherwise.
  always_comb begin
    accept = state_q == IDLE && bus.req;
    go_resp = LATENCY == 1 ? accept : state_q == WAIT && cnt_q == 4'd0;
    a_we = state_q == IDLE ? bus.we : we_q;
    a_addr = state_q == IDLE ? bus.addr : addr_q;
    a_wdata = state_q == IDLE ? bus.wdata : wdata_q;
    state_d = go_resp ? RESP : accept ? WAIT : state_q == WAIT ? WAIT : IDLE;
    cnt_d = accept ? CNT_INIT : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
`ifdef DMEM_RANGE_CHK_EN
    oob = 32'(a_addr) >= DEPTH;
`else
    oob = 1'b0;
`endif
  end
`ifndef DMEM_RANGE_CHK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^a_addr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= 16'h0;
      we_q <= 1'b0;
      addr_q <= 16'h0;
      wdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= state_d != IDLE;
      ack_q <= state_d == RESP;
      err_q <= go_resp && oob;
      if (accept) begin
        we_q <= bus.we;
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (go_resp && !a_we && !oob) rdata_q <= mem[a_addr[AW-1:0]];
    end
  end
  always_ff @(posedge clk)
    if (!rst && go_resp && a_we && !oob) mem[a_addr[AW-1:0]] <= a_wdata;
  assign bus.busy = busy_q;
  assign bus.ack = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (LATENCY 2 and LATENCY 1 instances)
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_ack;
  dmem_responder_if bus();
  dmem_responder_if bus1();
  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic acc(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input logic exp_err, input string tag);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0; bus.we = ~w; bus.addr = 16'hFFFF; bus.wdata = 16'h0;
    chk({tag, "_busy_wait"}, bus.busy, 1);
    chk({tag, "_ack_wait"}, bus.ack, 0);
    @(negedge clk);
    chk({tag, "_ack"}, bus.ack, 1);
    chk({tag, "_busy_resp"}, bus.busy, 1);
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    chk({tag, "_err"}, bus.err, exp_err);
    @(negedge clk);
    chk({tag, "_ack_done"}, bus.ack, 0);
    chk({tag, "_busy_done"}, bus.busy, 0);
  endtask
  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0; bus.wdata = 16'h0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 16'h0; bus1.wdata = 16'h0;
    repeat (2) @(negedge clk);
    bus.req = 1'b1;
    bus1.req = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst1_busy", bus1.busy, 0);
    chk("rst1_ack", bus1.ack, 0);
    chk("rst1_rdata", bus1.rdata, 0);
    chk("rst1_err", bus1.err, 0);
    bus.req = 1'b0;
    bus1.req = 1'b0;
    rst = 1'b0;
    acc(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "wr10");
    acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd10");
    acc(1'b1, 16'h0021, 16'h0000, 16'hBEEF, 1'b0, "pre21");
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h1111;
    @(negedge clk);
    bus.addr = 16'h0021; bus.wdata = 16'h2222;
    chk("ign_busy", bus.busy, 1);
    chk("ign_ack_wait", bus.ack, 0);
    @(negedge clk);
    bus.req = 1'b0;
    n_ack = int'(bus.ack);
    repeat (5) begin
      @(negedge clk);
      n_ack += int'(bus.ack);
    end
    chk("ign_ack_count", n_ack, 1);
    acc(1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b0, "rd21");
    acc(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, "rd20");
    acc(1'b1, 16'h0005, 16'h0000, 16'h1111, 1'b0, "pre5");
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0005; bus.wdata = 16'h1234;
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    chk("abort_busy_wait", bus.busy, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_rdata", bus.rdata, 0);
    @(negedge clk);
    chk("abort_ack_after", bus.ack, 0);
    acc(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, "rd5");
    acc(1'b1, 16'h0030, 16'h5A5A, 16'h0000, 1'b0, "wr30");
    acc(1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b0, "rd30");
    acc(1'b1, 16'h0031, 16'h7777, 16'h5A5A, 1'b0, "wr31_hold");
    chk("hold_rdata_after", bus.rdata, 16'h5A5A);
    acc(1'b1, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, "pre0");
`ifdef DMEM_RANGE_CHK_EN
    acc(1'b1, 16'h0100, 16'hAAAA, 16'h5A5A, 1'b1, "wr100");
    acc(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "rd0");
`else
    acc(1'b1, 16'h0100, 16'hAAAA, 16'h5A5A, 1'b0, "wr100");
    acc(1'b0, 16'h0000, 16'h0000, 16'hAAAA, 1'b0, "rd0");
`endif
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 16'h0007; bus1.wdata = 16'h4321;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("l1_ack_%0d", i), bus1.ack, i % 2 == 0);
      chk($sformatf("l1_busy_%0d", i), bus1.busy, i % 2 == 0);
      if (i == 0) bus1.we = 1'b0;
      if (i >= 2 && i % 2 == 0) chk($sformatf("l1_rdata_%0d", i), bus1.rdata, 16'h4321);
    end
    bus1.req = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
